// File: rtl/instr_feeder.sv
// Program buffer feeding the CPU instruction port: loads words, then streams one per clock after a start pulse.
// Run latency: start at T+1, word k at T+2+k. Load backpressure: ld_ready drops once the program is complete or the buffer is full.
module instr_feeder #(
  parameter int          DEPTH    = 256,
  parameter logic [4:0]  HALT_OP  = 5'b00001,
  parameter logic [15:0] NOP_WORD = 16'h0000,
  localparam int         AW       = $clog2(DEPTH),
  localparam int         LW       = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [15:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          run,
  input  logic          clr,
  output logic          enable,
  output logic          start,
  output logic [15:0]   i_datain,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] prog_len
);

  typedef enum logic [2:0] {
    IDLE,
    LOADED,
    START,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0]   HALT_WORD = {HALT_OP, 11'b0};
  localparam logic [LW-1:0] FULL_LEN  = LW'(DEPTH);

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [LW-1:0]   rd_ptr;
  logic            xfer;
  logic            go_start;
  logic            load_end;
  logic            issue_end;

  assign xfer      = ld_valid && ld_ready;
  assign load_end  = xfer && (ld_last || (prog_len == FULL_LEN - LW'(1)));
  // rd_ptr already points past the word on i_datain, so equality marks the last stored word
  assign issue_end = (i_datain[15:11] == HALT_OP) || (rd_ptr == prog_len);

  always_comb begin
    go_start = 1'b0;
    if (run) begin
      case (state)
        IDLE:         go_start = (prog_len != '0) && !(xfer && ld_last);
        LOADED, DONE: go_start = 1'b1;
        default:      go_start = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (xfer && !clr) begin
      mem[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      prog_len <= '0;
      ld_ready <= 1'b0;
      enable   <= 1'b0;
      start    <= 1'b0;
      i_datain <= NOP_WORD;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      enable <= 1'b1;
      start  <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        prog_len <= '0;
        ld_ready <= 1'b1;
        i_datain <= NOP_WORD;
        busy     <= 1'b0;
        done     <= 1'b0;
      end else begin
        if (xfer) begin
          wr_ptr   <= wr_ptr + AW'(1);
          prog_len <= prog_len + LW'(1);
        end
        if (go_start) begin
          state    <= START;
          start    <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          ld_ready <= 1'b0;
          rd_ptr   <= '0;
          i_datain <= NOP_WORD;
        end else begin
          case (state)
            IDLE: begin
              ld_ready <= !load_end;
              if (load_end) begin
                state <= LOADED;
              end
            end
            LOADED: begin
              ld_ready <= 1'b0;
            end
            START: begin
              state    <= RUN;
              i_datain <= mem[rd_ptr[AW-1:0]];
              rd_ptr   <= rd_ptr + LW'(1);
            end
            RUN: begin
              if (issue_end) begin
                state    <= DONE;
                i_datain <= HALT_WORD;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else begin
                i_datain <= mem[rd_ptr[AW-1:0]];
                rd_ptr   <= rd_ptr + LW'(1);
              end
            end
            DONE: begin
              i_datain <= HALT_WORD;
              done     <= 1'b1;
            end
            default: begin
              state <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
